// File: rtl/bcd_time_counter.sv
// 24-hour BCD time-of-day counter with a mode/inc button-driven setting FSM.
// All outputs are registered; digit arithmetic stays within 4 bits per digit.
module bcd_time_counter #(
  parameter logic [7:0] RESET_HOUR   = 8'h00,
  parameter logic [7:0] RESET_MINUTE = 8'h00,
  parameter logic [7:0] RESET_SECOND = 8'h00
) (
  input  logic       clk_1hz,
  input  logic       cr,
  input  logic       en,
  input  logic       mode,
  input  logic       inc,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic [1:0] set_state,
  output logic       day_carry
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10
  } state_t;

  state_t state;
  logic   mode_d;
  logic   mode_rise;

  logic [8:0] sec_nxt;
  logic [8:0] min_nxt;
  logic [8:0] hr_nxt;

  // One BCD step of a two-digit field; bit 8 flags the wrap from the top
  // value (top_t:top_u) back to 00. Each digit is handled as its own nibble.
  function automatic logic [8:0] bcd_step(input logic [7:0] val,
                                          input logic [3:0] top_t,
                                          input logic [3:0] top_u);
    logic [3:0] t;
    logic [3:0] u;
    t = val[7:4];
    u = val[3:0];
    if (t == top_t && u == top_u)
      return {1'b1, 8'h00};
    else if (u == 4'd9)
      return {1'b0, t + 4'd1, 4'd0};
    else
      return {1'b0, t, u + 4'd1};
  endfunction

  // Rising edge of the debounced mode level and per-field next values.
  always_comb begin
    mode_rise = mode & ~mode_d;
    sec_nxt   = bcd_step(second, 4'd5, 4'd9);
    min_nxt   = bcd_step(minute, 4'd5, 4'd9);
    hr_nxt    = bcd_step(hour,   4'd2, 4'd3);
  end

  // Setting FSM, time registers and the one-cycle day carry.
  always_ff @(posedge clk_1hz or posedge cr) begin
    if (cr) begin
      state     <= RUN;
      mode_d    <= 1'b0;
      hour      <= RESET_HOUR;
      minute    <= RESET_MINUTE;
      second    <= RESET_SECOND;
      day_carry <= 1'b0;
    end else begin
      mode_d    <= mode;
      day_carry <= 1'b0;
      case (state)
        RUN: begin
          if (mode_rise) begin
            state <= SET_H;
          end
          // The transition edge itself is still a RUN edge, so time counts.
          if (en) begin
            second <= sec_nxt[7:0];
            if (sec_nxt[8]) begin
              minute <= min_nxt[7:0];
              if (min_nxt[8]) begin
                hour <= hr_nxt[7:0];
                if (hr_nxt[8]) day_carry <= 1'b1;
              end
            end
          end
        end
        SET_H: begin
          if (mode_rise)  state <= SET_M;
          else if (inc)   hour  <= hr_nxt[7:0];
        end
        SET_M: begin
          if (mode_rise) begin
            state  <= RUN;
            second <= 8'h00;
          end else if (inc) begin
            minute <= min_nxt[7:0];
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign set_state = state;

endmodule
